// File: rtl/cherry_varray_pkg.sv
// Shared varray types: default widths, address/element typedefs, the
// read-sequencer state encoding and a saturating counter helper.
package cherry_varray_pkg;

  localparam int VIRTUAL_ADDR_BITS     = 16;
  localparam int VIRTUAL_ELEMENT_WIDTH = 18;
  localparam int GROUP_MAX_DEFAULT     = 8;
  // Wide enough to hold any GROUP_MAX in 1..32.
  localparam int GROUP_CNT_BITS        = 6;

  typedef logic [VIRTUAL_ADDR_BITS-1:0]     vaddr_t;
  typedef logic [VIRTUAL_ELEMENT_WIDTH-1:0] velem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/varray_seq_outreg.sv
// One-entry registered valid/ready output stage carrying data, address and
// group-start flag. A load always wins; otherwise a handshake empties it.
// The entry is held unchanged while valid and not ready.
module varray_seq_outreg
  import cherry_varray_pkg::*;
#(
  parameter int AW = cherry_varray_pkg::VIRTUAL_ADDR_BITS,
  parameter int DW = cherry_varray_pkg::VIRTUAL_ELEMENT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_dat,
  input  logic [AW-1:0] i_addr,
  input  logic          i_first,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_dat,
  output logic [AW-1:0] o_addr,
  output logic          o_first
);

  logic          r_valid;
  logic [DW-1:0] r_dat;
  logic [AW-1:0] r_addr;
  logic          r_first;

  // Load a new element, or drop valid once the consumer has taken it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_dat   <= '0;
      r_addr  <= '0;
      r_first <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_dat   <= i_dat;
      r_addr  <= i_addr;
      r_first <= i_first;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_dat   = r_dat;
  assign o_addr  = r_addr;
  assign o_first = r_first;

endmodule

// File: rtl/varray_read_sequencer.sv
// Read-side sequencer for one varray: walks [start_addr, end_addr) in strictly
// increasing order, stalls while the addressed element is not yet written,
// and hands elements to the instruction queue through a 1-entry output stage.
// Superscalar group starts are forwarded and groups are split every GROUP_MAX.
// Handshake: an element transfers on a cycle where out_valid && out_ready;
// while out_valid && !out_ready the output entry is held stable.
// Optional build macro VARRAY_SEQ_STATS_EN adds saturating stat_elems and
// stat_stalls counters (cleared only by reset).
module varray_read_sequencer
  import cherry_varray_pkg::*;
#(
  parameter int VIRTUAL_ADDR_BITS     = cherry_varray_pkg::VIRTUAL_ADDR_BITS,
  parameter int VIRTUAL_ELEMENT_WIDTH = cherry_varray_pkg::VIRTUAL_ELEMENT_WIDTH,
  parameter int GROUP_MAX             = cherry_varray_pkg::GROUP_MAX_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     start_addr,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     end_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             va_re,
  output logic [VIRTUAL_ADDR_BITS-1:0]     va_read_addr,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] va_dat_r,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     va_varray_len,
  input  logic                             va_is_new_group,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] out_dat,
  output logic [VIRTUAL_ADDR_BITS-1:0]     out_addr,
  output logic                             out_first,
`ifdef VARRAY_SEQ_STATS_EN
  output logic [31:0]                      stat_elems,
  output logic [31:0]                      stat_stalls,
`endif
  output seq_state_t                       dbg_state
);

  localparam int AW = VIRTUAL_ADDR_BITS;
  localparam logic [GROUP_CNT_BITS-1:0] GROUP_MAX_C = GROUP_CNT_BITS'(GROUP_MAX);

  seq_state_t                r_state;
  seq_state_t                w_next_state;
  logic [AW-1:0]             r_rd_addr;
  logic [AW-1:0]             r_end_addr;
  logic [AW-1:0]             r_last_addr;
  logic                      r_last_addr_valid;
  logic                      r_first_pending;
  logic [GROUP_CNT_BITS-1:0] r_group_cnt;

  logic          w_start_bad;
  logic          w_start_acc;
  logic          w_out_valid;
  logic          w_issue;
  logic          w_last_issue;
  logic          w_first;
  logic          w_stall;
  logic [AW-1:0] w_rd_next;

  // Start validation, issue decision and group-start computation.
  always_comb begin
    w_start_bad  = (end_addr < start_addr) ||
                   (r_last_addr_valid && (start_addr <= r_last_addr));
    w_start_acc  = start && (r_state == IDLE) && !w_start_bad;
    w_rd_next    = r_rd_addr + 1'b1;
    w_issue      = (r_state == RUN) && (r_rd_addr < r_end_addr) &&
                   (r_rd_addr < va_varray_len) && (!w_out_valid || out_ready);
    w_last_issue = w_issue && (w_rd_next == r_end_addr);
    w_first      = r_first_pending || va_is_new_group || (r_group_cnt == GROUP_MAX_C);
    w_stall      = (r_state == RUN) && (r_rd_addr >= va_varray_len);
  end

  // Next-state logic plus the done/err pulses.
  always_comb begin
    w_next_state = r_state;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_start_bad) begin
            err = 1'b1;
          end else if (start_addr == end_addr) begin
            // Empty range: pass straight through DRAIN to produce done.
            w_next_state = DRAIN;
          end else begin
            w_next_state = RUN;
          end
        end
      end
      RUN: begin
        if (w_last_issue) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_out_valid || out_ready) begin
          done         = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Read-address counter, range end, last-issued address and group counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr         <= '0;
      r_end_addr        <= '0;
      r_last_addr       <= '0;
      r_last_addr_valid <= 1'b0;
      r_first_pending   <= 1'b0;
      r_group_cnt       <= '0;
    end else if (w_start_acc) begin
      r_rd_addr       <= start_addr;
      r_end_addr      <= end_addr;
      r_first_pending <= 1'b1;
    end else if (w_issue) begin
      r_rd_addr         <= w_rd_next;
      r_last_addr       <= r_rd_addr;
      r_last_addr_valid <= 1'b1;
      r_first_pending   <= 1'b0;
      r_group_cnt       <= w_first ? GROUP_CNT_BITS'(1) : r_group_cnt + 1'b1;
    end
  end

  varray_seq_outreg #(
    .AW(VIRTUAL_ADDR_BITS),
    .DW(VIRTUAL_ELEMENT_WIDTH)
  ) u_outreg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_issue),
    .i_dat   (va_dat_r),
    .i_addr  (r_rd_addr),
    .i_first (w_first),
    .i_ready (out_ready),
    .o_valid (w_out_valid),
    .o_dat   (out_dat),
    .o_addr  (out_addr),
    .o_first (out_first)
  );

`ifdef VARRAY_SEQ_STATS_EN
  logic [31:0] r_stat_elems;
  logic [31:0] r_stat_stalls;

  // Saturating counts of issued reads and of RUN cycles stalled on length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_elems  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_issue) begin
        r_stat_elems <= sat_inc32(r_stat_elems);
      end
      if (w_stall) begin
        r_stat_stalls <= sat_inc32(r_stat_stalls);
      end
    end
  end

  assign stat_elems  = r_stat_elems;
  assign stat_stalls = r_stat_stalls;
`endif

  assign busy         = (r_state != IDLE);
  assign va_re        = w_issue;
  assign va_read_addr = r_rd_addr;
  assign out_valid    = w_out_valid;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_varray_read_sequencer.sv
// Bench for varray_read_sequencer (built with GROUP_MAX=4). A reference model
// keeps the expected element stream per range in a queue and tracks the
// expected read pointer, output occupancy, done/err pulses and stall counts.
module tb_varray_read_sequencer;
  import cherry_varray_pkg::*;

  localparam int AW = 16;
  localparam int DW = 18;
  localparam int GM = 4;
  localparam int MEM_N = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic          va_re;
  logic [AW-1:0] va_read_addr;
  logic [DW-1:0] va_dat_r;
  logic [AW-1:0] va_varray_len;
  logic          va_is_new_group;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_dat;
  logic [AW-1:0] out_addr;
  logic          out_first;
  seq_state_t    dbg_state;
`ifdef VARRAY_SEQ_STATS_EN
  logic [31:0]   stat_elems;
  logic [31:0]   stat_stalls;
`endif

  // varray contents and group flags
  logic [DW-1:0] mem [0:MEM_N-1];
  logic          newg_mem [0:MEM_N-1];

  assign va_dat_r        = mem[va_read_addr[9:0]];
  assign va_is_new_group = newg_mem[va_read_addr[9:0]];

  varray_read_sequencer #(
    .VIRTUAL_ADDR_BITS    (AW),
    .VIRTUAL_ELEMENT_WIDTH(DW),
    .GROUP_MAX            (GM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .va_re          (va_re),
    .va_read_addr   (va_read_addr),
    .va_dat_r       (va_dat_r),
    .va_varray_len  (va_varray_len),
    .va_is_new_group(va_is_new_group),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_dat        (out_dat),
    .out_addr       (out_addr),
    .out_first      (out_first),
`ifdef VARRAY_SEQ_STATS_EN
    .stat_elems     (stat_elems),
    .stat_stalls    (stat_stalls),
`endif
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard: {last_of_range, first, addr, data}
  logic [AW+DW+1:0] exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int          m_rd, m_end, m_last;
  bit          m_active, m_busy, m_ov, m_last_valid, m_empty_pending;
  bit          m_start_exp_err;
  logic [31:0] m_elems, m_stalls;
  int          obs_re_cnt, obs_first_cnt;
  bit          rand_ready, grow_len;
  int          len_cap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd = 0; m_end = 0; m_last = 0;
    m_active = 0; m_busy = 0; m_ov = 0; m_last_valid = 0; m_empty_pending = 0;
    m_start_exp_err = 0;
    m_elems = 0; m_stalls = 0;
  endtask

  // Per-cycle comparison against the model, done at the falling edge.
  task automatic monitor_cycle();
    bit               exp_re, hs, exp_done;
    logic [AW+DW+1:0] e;
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_ov);
    if (start && !m_busy) chk("err_start", err, m_start_exp_err);
    else                  chk("err_idle", err, 1'b0);
    exp_re = m_active && (m_rd < m_end) && (m_rd < int'(va_varray_len)) &&
             (!m_ov || out_ready);
    chk("va_re", va_re, exp_re);
    if (exp_re) chk("va_read_addr", va_read_addr, m_rd);
    if (va_re) obs_re_cnt++;
    hs = m_ov && out_ready;
    exp_done = 0;
    if (m_ov) begin
      if (exp_q.size() == 0) begin
        chk("queue_nonempty", 1'b0, 1'b1);
      end else begin
        e = exp_q[0];
        chk("out_addr", out_addr, e[AW+DW-1:DW]);
        chk("out_dat", out_dat, e[DW-1:0]);
        chk("out_first", out_first, e[AW+DW]);
        if (hs) begin
          void'(exp_q.pop_front());
          exp_done = e[AW+DW+1];
          if (out_first) obs_first_cnt++;
        end
      end
    end
    if (m_empty_pending) begin
      exp_done = 1;
      m_empty_pending = 0;
    end
    chk("done", done, exp_done);
    if (exp_done) m_busy = 0;
    if (m_active && (m_rd >= int'(va_varray_len))) m_stalls++;
    if (exp_re) begin
      m_ov = 1;
      m_last = m_rd;
      m_last_valid = 1;
      m_rd++;
      m_elems++;
      if (m_rd == m_end) m_active = 0;
    end else if (hs) begin
      m_ov = 0;
    end
  endtask

  // driver: one clock cycle (check at negedge, drive #1 after posedge)
  task automatic step();
    @(negedge clk);
    if (!reset) monitor_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (grow_len && ($urandom_range(0, 2) == 0) && (int'(va_varray_len) < len_cap))
      va_varray_len = va_varray_len + 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Pulse start for one cycle and load the model with the expected stream.
  task automatic start_range(input int s, input int e);
    bit was_busy;
    int cnt;
    bit f;
    logic [AW-1:0] a16;
    was_busy = m_busy;
    start_addr = AW'(s);
    end_addr   = AW'(e);
    start      = 1'b1;
    m_start_exp_err = (e < s) || (m_last_valid && (s <= m_last));
    step();
    start = 1'b0;
    if (!was_busy && !m_start_exp_err) begin
      m_busy = 1;
      cnt = 0;
      for (int a = s; a < e; a++) begin
        f = (a == s) || newg_mem[a] || (cnt == GM);
        cnt = f ? 1 : cnt + 1;
        a16 = AW'(a);
        exp_q.push_back({(a == e - 1), f, a16, mem[a]});
      end
      if (s == e) begin
        m_empty_pending = 1;
      end else begin
        m_active = 1;
        m_rd = s;
        m_end = e;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && (n < budget)) begin
      step();
      n++;
    end
    if (m_busy) chk("done_timeout", 1'b0, 1'b1);
    step();
  endtask

  initial begin
    int s, e, ln;
    for (int i = 0; i < MEM_N; i++) begin
      mem[i]      = DW'($urandom);
      newg_mem[i] = (i >= 31) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
    va_varray_len = '0; out_ready = 1'b1;
    rand_ready = 0; grow_len = 0; len_cap = 0;
    obs_re_cnt = 0; obs_first_cnt = 0;
    model_reset();

    // reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_va_re", va_re, 1'b0);
    chk("rst_rd_addr", va_read_addr, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_addr", out_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // basic range, always ready
    va_varray_len = 16'd10;
    obs_re_cnt = 0;
    start_range(0, 4);
    wait_idle(20);
    chk("t1_reads", obs_re_cnt, 4);

    // overlapping start, reversed range, then empty range
    start_range(3, 6);
    chk("t5_idle_after_err", busy, 1'b0);
    start_range(9, 2);
    obs_re_cnt = 0;
    start_range(4, 4);
    wait_idle(5);
    chk("t5_no_reads", obs_re_cnt, 0);

    // stall on length, then resume
    do_reset();
    va_varray_len = 16'd2;
    start_range(0, 5);
    repeat (6) step();
    chk("t2_stalled_busy", busy, 1'b1);
    va_varray_len = 16'd5;
    wait_idle(20);

    // backpressure mid-stream and start while busy
    va_varray_len = 16'd40;
    start_range(5, 20);
    repeat (3) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    start_addr = 16'd0; end_addr = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(40);

    // group splitting with no external group flags
    obs_first_cnt = 0;
    start_range(20, 30);
    wait_idle(30);
    chk("t4_first_count", obs_first_cnt, 3);

    // randomized ranges, lengths and backpressure
    rand_ready = 1;
    grow_len = 1;
    for (int r = 0; r < 10; r++) begin
      if (m_last_valid && ($urandom_range(0, 5) == 0)) begin
        s = m_last - int'($urandom_range(0, 2));
        if (s < 0) s = 0;
        e = s + int'($urandom_range(0, 5));
      end else begin
        s = m_last + 1 + int'($urandom_range(0, 3));
        e = s + int'($urandom_range(0, 12));
      end
      len_cap = e;
      ln = s + int'($urandom_range(0, 4));
      if (ln > int'(va_varray_len)) va_varray_len = AW'(ln);
      start_range(s, e);
      wait_idle(300);
    end
    rand_ready = 0;
    grow_len = 0;
    out_ready = 1'b1;
    chk("queue_drained", exp_q.size(), 0);
`ifdef VARRAY_SEQ_STATS_EN
    chk("stat_elems", stat_elems, m_elems);
    chk("stat_stalls", stat_stalls, m_stalls);
`endif

    // asynchronous reset between edges while running
    va_varray_len = 16'd1000;
    start_range(m_last + 1, m_last + 30);
    step();
    step();
    chk("t6_running", va_re, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_va_re", va_re, 1'b0);
    chk("t6_rd_addr", va_read_addr, 0);
`ifdef VARRAY_SEQ_STATS_EN
    chk("t6_stat_elems", stat_elems, 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
